// File: rtl/fetch_pc_unit.sv
// ============================================================================
// Module   : fetch_pc_unit
// Brief    : Fetch-stage program counter and IF/ID pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_unit #(
  parameter int unsigned          ADDRESS_WIDTH     = 32,
  parameter int unsigned          INSTRUCTION_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = 32'hBFC00000,
  parameter logic [ADDRESS_WIDTH-1:0] ROM_BASE      = 32'hBFC00000,
  parameter logic [ADDRESS_WIDTH-1:0] ROM_LAST      = 32'hBFC00FFC
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [ADDRESS_WIDTH-1:0]     pc_o,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_i,
  input  logic                         stall_i,
  input  logic                         redirect_i,
  input  logic [ADDRESS_WIDTH-1:0]     redirect_target_i,
  output logic                         if_id_valid_o,
  output logic [INSTRUCTION_WIDTH-1:0] if_id_instr_o,
  output logic [ADDRESS_WIDTH-1:0]     if_id_pc_o,
  output logic [ADDRESS_WIDTH-1:0]     if_id_pc_plus4_o,
  output logic                         fault_o,
  output logic [ADDRESS_WIDTH-1:0]     fault_addr_o
);

  localparam logic [INSTRUCTION_WIDTH-1:0] c_nop  = INSTRUCTION_WIDTH'(32'h00000013);
  localparam logic [ADDRESS_WIDTH-1:0]     c_four = ADDRESS_WIDTH'(4);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                         r_state;
  logic [ADDRESS_WIDTH-1:0]       r_pc;
  logic                           r_valid;
  logic [INSTRUCTION_WIDTH-1:0]   r_instr;
  logic [ADDRESS_WIDTH-1:0]       r_id_pc;
  logic [ADDRESS_WIDTH-1:0]       r_id_pc_plus4;
  logic                           r_fault;
  logic [ADDRESS_WIDTH-1:0]       r_fault_addr;

  logic [ADDRESS_WIDTH-1:0]       w_pc_plus4;
  logic                           w_target_legal;

  assign w_pc_plus4     = r_pc + c_four;
  assign w_target_legal = (redirect_target_i[1:0] == 2'b00) &&
                          (redirect_target_i >= ROM_BASE) &&
                          (redirect_target_i <= ROM_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_pc          <= RESET_VECTOR;
      r_valid       <= 1'b0;
      r_instr       <= c_nop;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= '0;
      r_fault       <= 1'b0;
      r_fault_addr  <= '0;
    end else begin
      case (r_state)
        BOOT: r_state <= RUN;
        RUN: begin
          if (redirect_i) begin
            // Redirect wins over stall: the wrong-path fetch is squashed either way.
            r_valid <= 1'b0;
            if (w_target_legal) begin
              r_pc <= redirect_target_i;
            end else begin
              r_state      <= HALT;
              r_fault      <= 1'b1;
              r_fault_addr <= redirect_target_i;
            end
          end else if (!stall_i) begin
            r_valid       <= 1'b1;
            r_instr       <= instr_i;
            r_id_pc       <= r_pc;
            r_id_pc_plus4 <= w_pc_plus4;
            if (r_pc == ROM_LAST) begin
              // Last word still issues; the overrun address is reported instead of fetched.
              r_state      <= HALT;
              r_fault      <= 1'b1;
              r_fault_addr <= w_pc_plus4;
            end else begin
              r_pc <= w_pc_plus4;
            end
          end
        end
        HALT: begin
          if (!stall_i) r_valid <= 1'b0;
        end
        default: r_state <= HALT;
      endcase
    end
  end

  assign pc_o             = r_pc;
  assign if_id_valid_o    = r_valid;
  assign if_id_instr_o    = r_instr;
  assign if_id_pc_o       = r_id_pc;
  assign if_id_pc_plus4_o = r_id_pc_plus4;
  assign fault_o          = r_fault;
  assign fault_addr_o     = r_fault_addr;

endmodule

`default_nettype wire
